// File: rtl/riscv_pkg.sv
// riscv_pkg: opcodes, control encodings and the decoded-control bundle for the decode stage
package riscv_pkg;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } alu_ctrl_t;
   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10
   } result_src_t;
   typedef enum logic [1:0] {
      IMM_I = 2'b00,
      IMM_S = 2'b01,
      IMM_B = 2'b10,
      IMM_J = 2'b11
   } imm_src_t;
   typedef struct packed {
      logic        reg_write;
      logic        mem_write;
      logic        jump;
      logic        branch;
      logic        alu_src;
      result_src_t result_src;
      alu_ctrl_t   alu_ctrl;
   } ctrl_t;
endpackage

// File: rtl/decode_stage_reg_file.sv
// reg_file: 32x32 register file, falling-edge write, write-before-read bypass, async active-low clear
module reg_file #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            we,
   input  logic [AW-1:0]   wa,
   input  logic [AW-1:0]   ra1,
   input  logic [AW-1:0]   ra2,
   input  logic [XLEN-1:0] wd,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2
);
   logic [XLEN-1:0] regs_q [NREGS];
   always_ff @(negedge clk or negedge reset)
      if (!reset)
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      else if (we && wa != '0)
         regs_q[wa] <= wd;
   // the bypass keeps a same-cycle writeback visible regardless of where in the cycle it lands
   assign rd1 = ra1 == '0 ? '0 : (we && wa == ra1) ? wd : regs_q[ra1];
   assign rd2 = ra2 == '0 ? '0 : (we && wa == ra2) ? wd : regs_q[ra2];
endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode + register file + ID/EX register; DECODE_ILLEGAL_EN adds IllegalE
module decode_stage
   import riscv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] InstrD,
   input  logic [XLEN-1:0] PCD,
   input  logic [XLEN-1:0] PCPlus4D,
   input  logic            RegWriteW,
   input  logic [4:0]      RdW,
   input  logic [XLEN-1:0] ResultW,
   input  logic            FlushE,
   output logic [4:0]      Rs1D,
   output logic [4:0]      Rs2D,
   output logic            RegWriteE,
   output logic            MemWriteE,
   output logic            JumpE,
   output logic            BranchE,
   output logic            ALUSrcE,
   output logic [1:0]      ResultSrcE,
   output logic [2:0]      ALUControlE,
   output logic [XLEN-1:0] RD1E,
   output logic [XLEN-1:0] RD2E,
   output logic [XLEN-1:0] ImmExtE,
   output logic [XLEN-1:0] PCE,
   output logic [XLEN-1:0] PCPlus4E,
   output logic [4:0]      RdE,
   output logic [4:0]      Rs1E,
   output logic [4:0]      Rs2E
`ifdef DECODE_ILLEGAL_EN
   ,output logic           IllegalE
`endif
);
   typedef struct packed {
      ctrl_t           ctrl;
      logic [XLEN-1:0] rd1, rd2, imm, pc, pc4;
      logic [4:0]      rd, rs1, rs2;
`ifdef DECODE_ILLEGAL_EN
      logic            illegal;
`endif
   } idex_t;
   idex_t           idex_d, idex_q;
   ctrl_t           ctrl;
   imm_src_t        imm_src;
   alu_ctrl_t       alu_fn;
   logic            has_imm, legal, fn_ok;
   logic [XLEN-1:0] imm, rf_rd1, rf_rd2;
   logic [6:0]      op;
   logic [2:0]      f3;
   assign op   = InstrD[6:0];
   assign f3   = InstrD[14:12];
   assign Rs1D = InstrD[19:15];
   assign Rs2D = InstrD[24:20];
   reg_file #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
      .clk(clk), .reset(reset), .we(RegWriteW), .wa(RdW), .ra1(Rs1D), .ra2(Rs2D),
      .wd(ResultW), .rd1(rf_rd1), .rd2(rf_rd2)
   );
   // only R-type honours funct7[5]; addi with that bit set still adds
   assign fn_ok  = f3 == 3'b000 || f3 == 3'b010 || f3 == 3'b110 || f3 == 3'b111;
   assign alu_fn = f3 == 3'b000 ? ((op == OP_RTYPE && InstrD[30]) ? ALU_SUB : ALU_ADD) :
                   f3 == 3'b010 ? ALU_SLT :
                   f3 == 3'b110 ? ALU_OR  :
                   f3 == 3'b111 ? ALU_AND : ALU_ADD;
   always_comb begin
      ctrl    = '0;
      imm_src = IMM_I;
      has_imm = 1'b1;
      legal   = 1'b1;
      case (op)
         OP_LOAD: begin
            ctrl.reg_write  = 1'b1;
            ctrl.alu_src    = 1'b1;
            ctrl.result_src = RES_MEM;
         end
         OP_STORE: begin
            ctrl.mem_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            imm_src        = IMM_S;
         end
         OP_RTYPE: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_ctrl  = alu_fn;
            has_imm        = 1'b0;
            legal          = fn_ok;
         end
         OP_IALU: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_ctrl  = alu_fn;
            legal          = fn_ok;
         end
         OP_BRANCH: begin
            ctrl.branch   = 1'b1;
            ctrl.alu_ctrl = ALU_SUB;
            imm_src       = IMM_B;
         end
         OP_JAL: begin
            ctrl.reg_write  = 1'b1;
            ctrl.jump       = 1'b1;
            ctrl.result_src = RES_PC4;
            imm_src         = IMM_J;
         end
         default: begin
            has_imm = 1'b0;
            legal   = 1'b0;
         end
      endcase
   end
   assign imm = !has_imm        ? '0 :
                imm_src == IMM_I ? {{(XLEN-12){InstrD[31]}}, InstrD[31:20]} :
                imm_src == IMM_S ? {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]} :
                imm_src == IMM_B ? {{(XLEN-12){InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0} :
                                   {{(XLEN-20){InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
   always_comb begin
      idex_d      = '0;
      idex_d.ctrl = ctrl;
      idex_d.rd1  = rf_rd1;
      idex_d.rd2  = rf_rd2;
      idex_d.imm  = imm;
      idex_d.pc   = PCD;
      idex_d.pc4  = PCPlus4D;
      idex_d.rd   = InstrD[11:7];
      idex_d.rs1  = Rs1D;
      idex_d.rs2  = Rs2D;
`ifdef DECODE_ILLEGAL_EN
      idex_d.illegal = !legal;
`endif
      if (FlushE) idex_d = '0;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) idex_q <= '0;
      else        idex_q <= idex_d;
   assign RegWriteE   = idex_q.ctrl.reg_write;
   assign MemWriteE   = idex_q.ctrl.mem_write;
   assign JumpE       = idex_q.ctrl.jump;
   assign BranchE     = idex_q.ctrl.branch;
   assign ALUSrcE     = idex_q.ctrl.alu_src;
   assign ResultSrcE  = idex_q.ctrl.result_src;
   assign ALUControlE = idex_q.ctrl.alu_ctrl;
   assign RD1E        = idex_q.rd1;
   assign RD2E        = idex_q.rd2;
   assign ImmExtE     = idex_q.imm;
   assign PCE         = idex_q.pc;
   assign PCPlus4E    = idex_q.pc4;
   assign RdE         = idex_q.rd;
   assign Rs1E        = idex_q.rs1;
   assign Rs2E        = idex_q.rs2;
`ifdef DECODE_ILLEGAL_EN
   assign IllegalE    = idex_q.illegal;
`else
   wire unused_legal = legal;
`endif
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction Decode (ID) stage of the 5-stage RV32I pipelined core; sits directly downstream of the Fetch stage.
- Consumes InstrD/PCD/PCPlus4D from the IF/ID register inside Fetch.
- Contains the main/ALU decoder, immediate extender and 32x32 register file with the writeback port.
- Registers all results into the ID/EX pipeline register feeding Execute; supports flush for branch/jump redirect and load-use bubbles.

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, architectural registers; x0 hardwired to zero.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- InstrD  in  32  instruction from Fetch
- PCD  in  32  PC of InstrD
- PCPlus4D  in  32  PCD+4
- RegWriteW  in  1  writeback enable
- RdW  in  5  writeback destination
- ResultW  in  32  writeback data
- FlushE  in  1  insert bubble into ID/EX
- Rs1D, Rs2D  out  5 each  source indices, combinational, for hazard unit
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  out  1 each  registered controls
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
- ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- RD1E, RD2E  out  32  register operands
- ImmExtE  out  32  extended immediate
- PCE, PCPlus4E  out  32  forwarded PC values
- RdE, Rs1E, Rs2E  out  5 each  register indices

Behaviour:
- Supported opcodes:
  - lw (0000011)
  - sw (0100011)
  - R-type (0110011): add, sub, and, or, slt
  - I-ALU (0010011): addi, andi, ori, slti
  - beq (1100011)
  - jal (1101111)
- Any other opcode decodes to all-zero controls, i.e. a NOP bubble.
- Controls per opcode:
  - lw: RegWrite=1, ALUSrc=1, ResultSrc=01.
  - sw: MemWrite=1, ALUSrc=1.
  - R-type: RegWrite=1.
  - I-ALU: RegWrite=1, ALUSrc=1.
  - beq: Branch=1, ALUControl=sub.
  - jal: RegWrite=1, Jump=1, ResultSrc=10.
- ALU decode:
  - lw/sw: add.
  - R-type and I-ALU by funct3: 000 add, 010 slt, 110 or, 111 and.
  - sub only for R-type with funct7[5]=1 and funct3=000; addi never subtracts.
  - Unlisted funct3 yields add.
- Immediates, sign bit InstrD[31] in all cases:
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - R-type: ImmExtD = 0.
- Register file:
  - Two combinational read ports (Rs1D=InstrD[19:15], Rs2D=InstrD[24:20]) and one write port.
  - Write occurs on the falling edge of clk when RegWriteW=1 and RdW!=0.
  - A same-cycle write and read of the same register returns ResultW, i.e. write-before-read in one cycle.
  - Reading x0 always returns 0; writes to x0 are dropped.
- ID/EX register:
  - Rising edge of clk; latency exactly 1 cycle from InstrD to the *E outputs.
  - FlushE=1 at a rising edge loads all control outputs (RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE) with 0.
  - On flush the data/index fields load 0 as well.
- Reset (reset=0, asynchronous):
  - All ID/EX outputs become 0 immediately.
  - All register file entries clear to 0.
  - Reset asserted mid-operation discards the in-flight instruction; the first valid decode occurs at the first rising edge after release.
- Simultaneous FlushE and a valid InstrD: flush wins.
- Simultaneous RegWriteW with RdW=0: no state change.

Optional Feature:
- Macro DECODE_ILLEGAL_EN.
- With the macro defined:
  - Adds output IllegalE (1 bit, registered alongside the controls, cleared by reset and FlushE).
  - IllegalE=1 when the opcode is unsupported, or when an R-type/I-ALU funct3 is outside {000,010,110,111}.
- Without the macro: the port is absent and unsupported encodings silently become NOPs.

Decomposition:
- Package riscv_pkg holds:
  - Opcode localparams: OP_LOAD, OP_STORE, OP_RTYPE, OP_IALU, OP_BRANCH, OP_JAL.
  - Enumerated typedefs alu_ctrl_t (3 bits), result_src_t (2 bits) and imm_src_t (I=00, S=01, B=10, J=11).
- One natural sub-module: reg_file (32x32, falling-edge write, async active-low clear).
- Decoder, extender and pipeline register stay in decode_stage.

Test Plan:
- Reset check: hold reset=0 for 2 cycles with InstrD=0xFFC12083 -> all *E outputs are 0; a register read returns 0.
- Same-cycle writeback: RegWriteW=1, RdW=5, ResultW=0x00001234 while InstrD=0x00028333 (add x6,x5,x0) -> next edge gives RD1E=0x00001234, RD2E=0, RegWriteE=1, ALUControlE=000, RdE=6.
- x0 protection: RegWriteW=1, RdW=0, ResultW=0xDEADBEEF, then InstrD=0x00000033 -> RD1E=RD2E=0.
- Load immediate: InstrD=0xFFC12083 (lw x1,-4(x2)) -> ImmExtE=0xFFFFFFFC, ResultSrcE=01, ALUSrcE=1, RegWriteE=1, Rs1E=2, RdE=1.
- Branch immediate: InstrD=0xFE000CE3 (beq x0,x0,-8), PCD=0x00000010 -> ImmExtE=0xFFFFFFF8, BranchE=1, ALUControlE=001, PCE=0x10, PCPlus4E=0x14.
- Flush: InstrD=0x0000006F (jal x0,0) with FlushE=1 -> JumpE=0, RegWriteE=0. The same instruction next cycle with FlushE=0 -> JumpE=1, ResultSrcE=10.
- Under DECODE_ILLEGAL_EN, InstrD=0x0000007F -> IllegalE=1 with all controls 0.
